// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, mcause codes,
// handshake FSM encoding and the byte-lane write merge used by every writable register.
package ysyx_220066_pkg;

  localparam logic [63:0] OFF_MSIP     = 64'h0000;
  localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
  localparam logic [63:0] OFF_MTIME    = 64'hBFF8;

  localparam logic [63:0] CAUSE_MSI = 64'h8000_0000_0000_0003;
  localparam logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  function automatic logic [63:0] wmask_merge(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wmask);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{wmask[i]}};
    return (wdata & m) | (old_val & ~m);
  endfunction

endpackage

// File: rtl/ysyx_220066_mtimer.sv
// mtime counter with its prescaler and bus write port; a bus write to mtime
// takes priority over the increment that would happen in the same cycle.
module ysyx_220066_mtimer
  import ysyx_220066_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wen,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wmask,
  output logic [63:0] o_mtime,
  output logic        o_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;
  logic          w_tick;

  assign w_tick  = (r_pre == PRE_LAST);
  assign o_tick  = w_tick;
  assign o_mtime = r_mtime;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre   <= '0;
      r_mtime <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (i_wen)
        r_mtime <= wmask_merge(r_mtime, i_wdata, i_wmask);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_220066_clint.sv
// Core-local interruptor: memory-mapped msip/mtimecmp/mtime with a one-cycle bus,
// plus the request/acknowledge FSM that hands timer and software interrupts to the CSR unit.
module ysyx_220066_clint
  import ysyx_220066_pkg::*;
#(
  parameter int          TICK_DIV = 1,
  parameter logic [63:0] BASE     = 64'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_wen,
  input  logic [63:0] bus_addr,
  input  logic [63:0] bus_wdata,
  input  logic [7:0]  bus_wmask,
  output logic [63:0] bus_rdata,
  output logic        bus_ready,
  output logic        bus_err,
  input  logic        intr_en,
  output logic        intr_req,
  output logic [63:0] intr_no,
  input  logic        intr_ack
);

  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [63:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic [1:0]  r_state;
  logic        r_src_sw;
  logic [63:0] r_no;

  logic        w_hit_msip, w_hit_cmp, w_hit_time, w_hit, w_wr;
  logic [63:0] w_mtime;
  logic        w_tick_unused;
  logic        w_mtip;
  logic        w_src_pending;
  logic [63:0] w_rd_data;

  assign w_hit_msip = (bus_addr == BASE + OFF_MSIP);
  assign w_hit_cmp  = (bus_addr == BASE + OFF_MTIMECMP);
  assign w_hit_time = (bus_addr == BASE + OFF_MTIME);
  assign w_hit      = w_hit_msip | w_hit_cmp | w_hit_time;
  assign w_wr       = bus_valid & bus_wen;

  ysyx_220066_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clk     (clk),
    .rst     (rst),
    .i_wen   (w_wr & w_hit_time),
    .i_wdata (bus_wdata),
    .i_wmask (bus_wmask),
    .o_mtime (w_mtime),
    .o_tick  (w_tick_unused)
  );

  assign w_mtip = (w_mtime >= r_mtimecmp);

  always_comb begin
    w_rd_data = '0;
    if (w_hit_msip)      w_rd_data = {63'd0, r_msip};
    else if (w_hit_cmp)  w_rd_data = r_mtimecmp;
    else if (w_hit_time) w_rd_data = w_mtime;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      r_ready <= bus_valid;
      r_err   <= bus_valid & ~w_hit;
      r_rdata <= (bus_valid & ~bus_wen) ? w_rd_data : '0;
      if (w_wr & w_hit_cmp)
        r_mtimecmp <= wmask_merge(r_mtimecmp, bus_wdata, bus_wmask);
      if (w_wr & w_hit_msip & bus_wmask[0])
        r_msip <= bus_wdata[0];
    end
  end

  // BUSY waits on the source that was latched, so the same event cannot re-raise.
  assign w_src_pending = r_src_sw ? r_msip : w_mtip;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_src_sw <= 1'b0;
      r_no     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (intr_en & (r_msip | w_mtip)) begin
            r_state  <= ST_REQ;
            r_src_sw <= r_msip;
            r_no     <= r_msip ? CAUSE_MSI : CAUSE_MTI;
          end
        end
        ST_REQ: begin
          if (intr_ack) r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (!w_src_pending) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign intr_req  = (r_state == ST_REQ);
  assign intr_no   = r_no;
  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_ysyx_220066_clint.sv
// Bench for the CLINT: directed scenarios followed by random bus/ack/enable traffic,
// all checked every cycle against a behavioural model of mtime, mtimecmp, msip and the handshake.
module tb_ysyx_220066_clint;

  localparam int          TD     = 4;
  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] A_BAD  = BASE + 64'h1000;
  localparam logic [63:0] MSI    = 64'h8000_0000_0000_0003;
  localparam logic [63:0] MTI    = 64'h8000_0000_0000_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_wen = 1'b0;
  logic [63:0] bus_addr = '0;
  logic [63:0] bus_wdata = '0;
  logic [7:0]  bus_wmask = '0;
  logic [63:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;
  logic        intr_en = 1'b0;
  logic        intr_req;
  logic [63:0] intr_no;
  logic        intr_ack = 1'b0;

  always #5 clk = ~clk;

  ysyx_220066_clint #(.TICK_DIV(TD), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (bus_valid),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_err   (bus_err),
    .intr_en   (intr_en),
    .intr_req  (intr_req),
    .intr_no   (intr_no),
    .intr_ack  (intr_ack)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: phase 0 = no interrupt outstanding, 1 = waiting for ack, 2 = taken.
  logic [63:0] m_time, m_cmp, m_no, e_rdata;
  int          m_pre, m_phase;
  bit          m_msip, m_src_sw;
  bit          e_ready, e_err, e_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    bit sw, tm, tick, wr;
    if (!rst) begin
      m_time = 0; m_pre = 0; m_cmp = '1; m_msip = 0;
      m_phase = 0; m_no = 0; m_src_sw = 0;
      e_ready = 0; e_err = 0; e_rd = 0; e_rdata = 0;
      return;
    end
    sw = m_msip;
    tm = (m_time >= m_cmp);
    wr = bus_valid && bus_wen;
    e_ready = bus_valid;
    e_rd    = bus_valid && !bus_wen;
    e_err   = bus_valid && !(bus_addr inside {A_MSIP, A_CMP, A_TIME});
    e_rdata = 0;
    if (e_rd) begin
      if (bus_addr == A_MSIP)      e_rdata = {63'd0, m_msip};
      else if (bus_addr == A_CMP)  e_rdata = m_cmp;
      else if (bus_addr == A_TIME) e_rdata = m_time;
    end
    if (m_phase == 0) begin
      if (intr_en && (sw || tm)) begin
        m_phase = 1; m_src_sw = sw; m_no = sw ? MSI : MTI;
      end
    end else if (m_phase == 1) begin
      if (intr_ack) m_phase = 2;
    end else begin
      if (!(m_src_sw ? sw : tm)) m_phase = 0;
    end
    tick  = (m_pre == TD - 1);
    m_pre = (m_pre + 1) % TD;
    if (wr && bus_addr == A_TIME)      m_time = merge(m_time, bus_wdata, bus_wmask);
    else if (tick)                     m_time = m_time + 64'd1;
    if (wr && bus_addr == A_CMP)       m_cmp = merge(m_cmp, bus_wdata, bus_wmask);
    if (wr && bus_addr == A_MSIP && bus_wmask[0]) m_msip = bus_wdata[0];
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("req", {63'd0, intr_req}, {63'd0, m_phase == 1});
    if (m_phase == 1) chk("no", intr_no, m_no);
    chk("ready", {63'd0, bus_ready}, {63'd0, e_ready});
    chk("err", {63'd0, bus_err}, {63'd0, e_err});
    if (e_rd) chk("rdata", bus_rdata, e_rdata);
    bus_valid = 1'b0;
    intr_ack  = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic [63:0] d);
    bus_valid = 1'b1; bus_wen = 1'b0; bus_addr = a;
    cycle();
    d = bus_rdata;
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    bus_valid = 1'b1; bus_wen = 1'b1; bus_addr = a; bus_wdata = d; bus_wmask = m;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int k;

    rst = 1'b0;
    cycle(); cycle();
    chk("rst_req", {63'd0, intr_req}, 64'd0);
    chk("rst_no", intr_no, 64'd0);
    chk("rst_ready", {63'd0, bus_ready}, 64'd0);
    chk("rst_err", {63'd0, bus_err}, 64'd0);
    chk("rst_rdata", bus_rdata, 64'd0);

    rst = 1'b1;
    bus_rd(A_CMP, d);
    chk("cmp_reset", d, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cmp_ready", {63'd0, bus_ready}, 64'd1);
    chk("cmp_err", {63'd0, bus_err}, 64'd0);
    cycle();
    chk("ready_pulse", {63'd0, bus_ready}, 64'd0);

    rst = 1'b0; cycle(); rst = 1'b1;
    repeat (40) cycle();
    bus_rd(A_TIME, d);
    chk("mtime40", d, 64'd10);

    k = 0;
    while (m_pre != TD - 1 && k < 10) begin cycle(); k++; end
    bus_wr(A_TIME, 64'd5, 8'hFF);
    bus_rd(A_TIME, d);
    chk("mtime_wr_tick", d, 64'd5);

    rst = 1'b0; cycle(); rst = 1'b1;
    intr_en = 1'b1;
    bus_wr(A_CMP, 64'd3, 8'hFF);
    k = 0;
    while (!intr_req && k < 100) begin cycle(); k++; end
    chk("mti_raise", {63'd0, intr_req}, 64'd1);
    chk("mti_no", intr_no, MTI);
    bus_rd(A_TIME, d);
    chk("mti_time", {63'd0, d >= 64'd3}, 64'd1);
    intr_ack = 1'b1;
    cycle();
    chk("ack_drop", {63'd0, intr_req}, 64'd0);
    repeat (10) cycle();
    chk("busy_hold", {63'd0, intr_req}, 64'd0);
    bus_wr(A_CMP, 64'd1000, 8'hFF);
    repeat (10) cycle();
    chk("no_rereq", {63'd0, intr_req}, 64'd0);

    intr_en = 1'b0;
    bus_wr(A_CMP, 64'd0, 8'hFF);
    bus_wr(A_MSIP, 64'd1, 8'h01);
    repeat (5) cycle();
    chk("en0_hold", {63'd0, intr_req}, 64'd0);
    intr_en = 1'b1;
    cycle();
    chk("en1_req", {63'd0, intr_req}, 64'd1);
    chk("sw_wins", intr_no, MSI);

    bus_rd(A_BAD, d);
    chk("bad_err", {63'd0, bus_err}, 64'd1);
    chk("bad_rdata", d, 64'd0);
    bus_wr(A_BAD, 64'h1234, 8'hFF);
    chk("bad_wr_err", {63'd0, bus_err}, 64'd1);

    bus_valid = 1'b1; bus_wen = 1'b0; bus_addr = A_CMP;
    rst = 1'b0;
    cycle();
    chk("rst_in_req", {63'd0, intr_req}, 64'd0);
    chk("rst_no_ready", {63'd0, bus_ready}, 64'd0);
    rst = 1'b1;
    bus_rd(A_TIME, d);
    chk("rst_mtime", d, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) intr_en = ~intr_en;
      intr_ack = ($urandom_range(0, 3) == 0);
      if (!e_ready && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       bus_addr = A_MSIP;
          1:       bus_addr = A_CMP;
          2:       bus_addr = A_TIME;
          default: bus_addr = A_BAD;
        endcase
        bus_wen   = ($urandom_range(0, 1) == 1);
        bus_wdata = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                : 64'($urandom_range(0, 60));
        bus_wmask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        bus_valid = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_clint.md
# ysyx_220066_clint

Core-local interruptor: the initiator side of the core's trap interface. It keeps the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` software-interrupt bit, all memory-mapped on the data bus. It raises machine timer and software interrupts toward the CSR unit over a request/acknowledge handshake and supplies the `mcause` code. It sits beside the LSU on the data bus; its interrupt outputs feed the CSR unit's `raise_intr`/`NO` inputs through the writeback stage.

## Interface
- `TICK_DIV`, 1: core cycles per `mtime` increment (≥1).
- `BASE`, 64'h0200_0000: bus base address.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low (reset when `rst`=0 at a `clk` rising edge).
- `bus_valid` in 1: access request, single-cycle pulse.
- `bus_wen` in 1: 1 = write, 0 = read.
- `bus_addr` in 64: byte address, 8-byte aligned.
- `bus_wdata` in 64: write data.
- `bus_wmask` in 8: byte enables for writes.
- `bus_rdata` out 64: read data, valid with `bus_ready`.
- `bus_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: unmapped address, valid with `bus_ready`.
- `intr_en` in 1: `mstatus.MIE` from the CSR unit.
- `intr_req` out 1: interrupt request to the core.
- `intr_no` out 64: `mcause` value, stable while `intr_req`=1.
- `intr_ack` in 1: core has taken the trap; one-cycle pulse.

## Operation
- Register map: `BASE+0x0000` msip (bit 0 only, other bits read 0); `BASE+0x4000` mtimecmp; `BASE+0xBFF8` mtime. Any other address gives `bus_err`=1, rdata 0, writes ignored.
- Writes merge `bus_wdata` byte-wise under `bus_wmask`.
- Prescaler counts 0..`TICK_DIV`-1. On wrap, `mtime` increments by 1 and wraps modulo 2^64.
- `mtip` = (`mtime` ≥ `mtimecmp`), unsigned, combinational on the current register values. `msip_p` = msip[0].
- Priority: software over timer. Codes are 64'h8000_0000_0000_0003 (MSI) and 64'h8000_0000_0000_0007 (MTI).
- FSM:
  - IDLE: if `intr_en` & (`msip_p` | `mtip`), latch the winning source and code, then go to REQ.
  - REQ: `intr_req`=1. Stay until `intr_ack`, then go to BUSY. The request is not retracted if `intr_en` or the source drops.
  - BUSY: `intr_req`=0. Return to IDLE once the latched source is no longer pending (software clears msip, or raises mtimecmp). This prevents re-raising the same event.
- `intr_ack` outside REQ is ignored.

## Timing
- Reset values:
  - `mtime`=0, prescaler=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - FSM in IDLE; `intr_req`=0, `intr_no`=0.
  - `bus_ready`=0, `bus_err`=0, `bus_rdata`=0.
- Reset mid-handshake returns to IDLE immediately. A pending `bus_valid` in the reset cycle gets no `bus_ready`.
- Bus latency is exactly one cycle: `bus_valid` at cycle N gives `bus_ready`/`bus_rdata`/`bus_err` at N+1. Read data reflects register values at cycle N. The write takes effect at the N edge.
- Simultaneous bus write to `mtime` and tick: the write wins, with no increment that cycle.
- Interrupt latency: a source becomes pending at cycle N (register updated at edge N-1). IDLE sees it at N and `intr_req` rises at N+1.
- `intr_ack` at cycle M: `intr_req`=0 at M+1.
- Writes at cycle N are visible to the pending logic from N+1.

## Structure
- Shared package `ysyx_220066_pkg`: register offsets, the two `mcause` codes, and FSM state encoding (IDLE/REQ/BUSY).
- One natural sub-module: `ysyx_220066_mtimer`, which holds the prescaler, `mtime` and its write port, and outputs `mtime` plus a tick strobe.
- The bus decode and FSM live in the top module.

## Test plan
- Reset, then read `BASE+0x4000` → rdata 64'hFFFF_FFFF_FFFF_FFFF, `bus_ready` 1 cycle later, `bus_err`=0.
- `TICK_DIV`=4, no writes for 40 cycles after reset, read `mtime` → 10. Write `mtime`=5 on a tick cycle → read back 5.
- `intr_en`=1, write mtimecmp=3 with `TICK_DIV`=1:
  - `intr_req` rises when mtime≥3, with `intr_no`=…0007.
  - Ack, then `intr_req`=0 next cycle and the FSM stays in BUSY.
  - Write mtimecmp=1000 → FSM back to IDLE, with no second request.
- Write msip=1 while mtime≥mtimecmp, `intr_en`=1 → `intr_no`=…0003 (software wins).
- `intr_en`=0 with msip=1 → `intr_req` stays 0. Set `intr_en`=1 → `intr_req` rises the next cycle.
- Read `BASE+0x1000` → `bus_err`=1, rdata=0. Drive `rst`=0 while in REQ → `intr_req`=0 and mtime=0 after the edge.
